// File: rtl/gdiv_u_pkg.sv
// Shared types and helpers for the unary bitstream decoder.
// GDIV_U_DECODE_BIPOLAR_EN selects the bipolar result encoding in gdiv_u_decode.
package gdiv_u_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } dec_state_t;

  // Window length in cycles for a given window exponent.
  function automatic int win_len(input int dep);
    return 1 << dep;
  endfunction

  // Bipolar value 2*ones - n. The only value that does not fit is +n, so it is clamped to n-1.
  function automatic int bipolar_val(input int ones, input int n);
    int v;
    v = 2 * ones - n;
    if (v > n - 1) v = n - 1;
    return v;
  endfunction

endpackage

// File: rtl/gdiv_u_decode_win.sv
// Window counter for gdiv_u_decode: counts samples and ones over 2^DEP cycles.
// close pulses combinationally in the last window cycle. count then includes that cycle's sample.
module gdiv_u_decode_win
  import gdiv_u_pkg::*;
#(
  parameter int DEP = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic         bit_in,
  output logic         close,
  output logic [DEP:0] count
);

  localparam int W = DEP + 1;
  localparam logic [DEP-1:0] LAST = DEP'(win_len(DEP) - 1);

  logic [DEP-1:0] win_cnt;
  logic [DEP:0]   ones_cnt;

  // Sample and ones counters. They clear on window entry and on close, so a new window starts at zero.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt  <= '0;
      ones_cnt <= '0;
    end else if (clear || close) begin
      win_cnt  <= '0;
      ones_cnt <= '0;
    end else if (en) begin
      win_cnt  <= win_cnt + DEP'(1);
      ones_cnt <= ones_cnt + W'(bit_in);
    end
  end

  assign close = en && (win_cnt == LAST);
  assign count = ones_cnt + W'(bit_in);

endmodule

// File: rtl/gdiv_u_decode.sv
// Unary-to-binary decoder. Counts ones in a bitstream over 2^DEP cycles and presents
// the count on a valid/ready port. Define GDIV_U_DECODE_BIPOLAR_EN to report
// 2*ones - N (saturated) instead of the raw ones count.
module gdiv_u_decode
  import gdiv_u_pkg::*;
#(
  parameter int DEP  = 5,
  parameter int CONT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         bitIn,
  input  logic         outReady,
  output logic         busy,
  output logic         outValid,
  output logic [DEP:0] outData,
  output logic         overrun
);

  localparam int W = DEP + 1;

  dec_state_t   state;
  dec_state_t   next_state;
  logic         win_close;
  logic [DEP:0] win_count;
  logic [DEP:0] result;

  gdiv_u_decode_win #(
    .DEP (DEP)
  ) u_win (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  ((state == IDLE) && start),
    .en     (state == ACC),
    .bit_in (bitIn),
    .close  (win_close),
    .count  (win_count)
  );

`ifdef GDIV_U_DECODE_BIPOLAR_EN
  localparam int N = win_len(DEP);
  assign result = W'(bipolar_val(int'(win_count), N));
`else
  assign result = win_count;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state: start opens a window. The close either ends the run or, in continuous mode, rolls into the next window.
  // NOTE: next_state defaults to state before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = ACC;
      ACC:  if (win_close && (CONT == 0)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output register and handshake. A load wins over a transfer. Overwriting an unconsumed result sets the sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid <= 1'b0;
      outData  <= '0;
      overrun  <= 1'b0;
    end else if (win_close) begin
      outData  <= result;
      outValid <= 1'b1;
      if (outValid && !outReady) overrun <= 1'b1;
    end else if (outValid && outReady) begin
      outValid <= 1'b0;
    end
  end

  assign busy = (state == ACC);

endmodule

// File: tb/tb_gdiv_u_decode.sv
// Self-checking bench for gdiv_u_decode. It uses three instances:
// a: DEP=3, one-shot mode. b: DEP=3, continuous mode. c: DEP=5, continuous mode.
// Define GDIV_U_DECODE_BIPOLAR_EN to check the bipolar build.
module tb_gdiv_u_decode;

  logic clk;
  logic rst_n;

  logic       a_start, a_bit, a_ready, a_busy, a_valid, a_ovr;
  logic [3:0] a_data;
  logic       b_start, b_bit, b_ready, b_busy, b_valid, b_ovr;
  logic [3:0] b_data;
  logic       c_start, c_bit, c_ready, c_busy, c_valid, c_ovr;
  logic [5:0] c_data;

  int n_tests = 0;
  int n_fail  = 0;
  int q_a[$];
  int q_c[$];
  int a_results = 0;
  int c_results = 0;

  gdiv_u_decode #(.DEP(3), .CONT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .bitIn(a_bit), .outReady(a_ready),
    .busy(a_busy), .outValid(a_valid), .outData(a_data), .overrun(a_ovr));

  gdiv_u_decode #(.DEP(3), .CONT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .bitIn(b_bit), .outReady(b_ready),
    .busy(b_busy), .outValid(b_valid), .outData(b_data), .overrun(b_ovr));

  gdiv_u_decode #(.DEP(5), .CONT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .bitIn(c_bit), .outReady(c_ready),
    .busy(c_busy), .outValid(c_valid), .outData(c_data), .overrun(c_ovr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outData for a window of 2^dep samples containing the given number of ones.
  function automatic int exp_val(input int ones, input int dep);
    int n;
    int v;
    n = 1 << dep;
`ifdef GDIV_U_DECODE_BIPOLAR_EN
    v = 2 * ones - n;
    if (v > n - 1) v = n - 1;
`else
    v = ones;
`endif
    return v & ((1 << (dep + 1)) - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for instance a: check every transfer against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && a_valid && a_ready) begin
      if (q_a.size() == 0) check("a_unexpected", 1, 0);
      else                 check("a_data", 32'(a_data), q_a.pop_front());
      a_results++;
    end
  end

  // Scoreboard for instance c.
  always @(negedge clk) begin
    if (rst_n && c_valid && c_ready) begin
      if (q_c.size() == 0) check("c_unexpected", 1, 0);
      else                 check("c_data", 32'(c_data), q_c.pop_front());
      c_results++;
    end
  end

  initial begin
    int ones;
    int seen;
    logic [15:0] lfsr;
    logic b;

    rst_n = 1'b0;
    {a_start, a_bit, a_ready} = '0;
    {b_start, b_bit, b_ready} = '0;
    {c_start, c_bit, c_ready} = '0;

    // Reset state
    #12;
    check("rst_a_valid", 32'(a_valid), 0);
    check("rst_a_data",  32'(a_data),  0);
    check("rst_a_busy",  32'(a_busy),  0);
    check("rst_b_ovr",   32'(b_ovr),   0);
    check("rst_c_valid", 32'(c_valid), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // All ones, one-shot mode: result appears 9 cycles after the start cycle
    a_ready = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("t1_busy_acc", 32'(a_busy), 1);
    for (int i = 0; i < 8; i++) begin
      a_bit = 1'b1;
      if (i == 7) q_a.push_back(exp_val(8, 3));
      tick();
      if (i == 6) check("t1_lat_early", 32'(a_valid), 0);
    end
    check("t1_lat",       32'(a_valid), 1);
    check("t1_busy_done", 32'(a_busy),  0);
    a_bit = 1'b0;
    repeat (3) tick();
    check("t1_count", 32'(a_results), 1);
    check("t1_valid_clr", 32'(a_valid), 0);

    // Pattern 1,0 with start pulses during ACC
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_bit   = (i % 2 == 0);
      a_start = (i == 2 || i == 5);
      if (i == 7) q_a.push_back(exp_val(4, 3));
      tick();
    end
    a_start = 1'b0;
    a_bit   = 1'b0;
    repeat (12) tick();
    check("t2_count", 32'(a_results), 2);
    check("t2_sb_empty", 32'(q_a.size()), 0);
    check("t2_busy", 32'(a_busy), 0);

    // Backpressure, continuous mode: ones window, then zeros window overwrites
    b_ready = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b_bit = (i < 8);
      tick();
      if (i == 7) begin
        check("t3_w1_data",  32'(b_data),  exp_val(8, 3));
        check("t3_w1_valid", 32'(b_valid), 1);
        check("t3_w1_ovr",   32'(b_ovr),   0);
      end
    end
    check("t3_w2_data",  32'(b_data),  exp_val(0, 3));
    check("t3_w2_ovr",   32'(b_ovr),   1);
    check("t3_w2_valid", 32'(b_valid), 1);
    b_bit = 1'b0;
    repeat (20) tick();
    check("t3_ovr_sticky", 32'(b_ovr), 1);
    rst_n = 1'b0;
    #1;
    check("t3_ovr_rst", 32'(b_ovr),  0);
    check("t3_busy_rst", 32'(b_busy), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Transfer and load in the same cycle
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b_bit   = (i < 3) || (i >= 8 && i < 13);
      b_ready = (i == 15);
      if (i == 15) check("t4_w1_data", 32'(b_data), exp_val(3, 3));
      tick();
    end
    b_ready = 1'b0;
    check("t4_valid", 32'(b_valid), 1);
    check("t4_data",  32'(b_data),  exp_val(5, 3));
    check("t4_ovr",   32'(b_ovr),   0);

    // Reset in the middle of a window
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_bit   = 1'b1;
    repeat (4) tick();
    check("t5_busy_pre", 32'(a_busy), 1);
    rst_n = 1'b0;
    #1;
    check("t5_busy",  32'(a_busy),  0);
    check("t5_valid", 32'(a_valid), 0);
    check("t5_data",  32'(a_data),  0);
    check("t5_ovr",   32'(a_ovr),   0);
    check("t5_b_valid", 32'(b_valid), 0);
    check("t5_b_data",  32'(b_data),  0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (a_valid || a_busy) seen = 1;
    end
    check("t5_no_output", 32'(seen), 0);
    a_bit = 1'b0;

    // Random stream, DEP=5: 100 back-to-back windows at about 25% ones density
    c_ready = 1'b1;
    lfsr = 16'hACE1;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    for (int w = 0; w < 100; w++) begin
      ones = 0;
      for (int i = 0; i < 32; i++) begin
        b = (lfsr[1:0] == 2'b00);
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        c_bit = b;
        ones += int'(b);
        if (i == 31) q_c.push_back(exp_val(ones, 5));
        tick();
      end
    end
    c_bit = 1'b0;
    repeat (3) tick();
    check("t6_count",    32'(c_results),  100);
    check("t6_sb_empty", 32'(q_c.size()), 0);
    check("t6_ovr",      32'(c_ovr),      0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gdiv_u_decode.md
Name: gdiv_u_decode

Overview:
- Unary-to-binary decoder at the consuming end of the unary bitstream datapath.
- Counts '1's in a single-bit stochastic bitstream over a fixed window of 2^DEP cycles, e.g. the quotient stream of the unary divider.
- Presents the count as a binary word on a valid/ready output port.
- Used to read back unary kernel results for checking and for binary hand-off to downstream logic.

Parameters:
- DEP, 5: window exponent. Window length is N = 2^DEP cycles; the result word is DEP+1 bits wide.
- CONT, 0: 1 = a new window starts automatically when the previous one closes; 0 = one window per start pulse.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous reset, active low
- start  input  1  begin a window; ignored unless state is IDLE
- bitIn  input  1  unary bitstream, sampled every ACC cycle
- outReady  input  1  downstream accepts outData this cycle
- busy  output  1  high while state is ACC
- outValid  output  1  outData holds an unconsumed result
- outData  output  DEP+1  ones count over the window, range 0..N
- overrun  output  1  sticky; set when an unconsumed result is overwritten

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; winCnt=0; onesCnt=0.
  - outValid=0, outData=0, overrun=0, busy=0.
  - Reset mid-window abandons the window with no output.
- States: IDLE, ACC.
- IDLE -> ACC on a cycle with start=1.
  - The first bitIn sample is taken in the first ACC cycle, i.e. the cycle after start.
  - winCnt and onesCnt are cleared on entry.
- ACC, every cycle:
  - onesCnt += bitIn (DEP+1 bits, cannot overflow since its maximum is N).
  - winCnt += 1 (DEP bits).
- Window close: an ACC cycle with winCnt = N-1 (all ones).
  - Next edge: outData <= onesCnt + bitIn; outValid <= 1.
  - Result latency is 1 cycle after the last sample.
  - Exactly N samples are counted per window.
  - CONT=0: state goes to IDLE.
  - CONT=1: state stays ACC with winCnt=0 and onesCnt=0. There is no gap cycle; the next sample belongs to the new window.
- start while in ACC: ignored (no restart, no error).
- Output handshake:
  - Transfer occurs on a cycle with outValid=1 and outReady=1.
  - After a transfer with no new result loading in the same cycle, outValid <= 0 at the next edge.
  - outData is held stable while outValid=1 and outReady=0.
- Result load collisions:
  - Result loads while outValid=1 and outReady=0: outData is overwritten with the new result, outValid stays 1, overrun <= 1.
  - Result loads in the same cycle as a transfer: the old value is consumed, the new value loads, outValid stays 1, overrun unchanged.
- overrun clears only on reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro GDIV_U_DECODE_BIPOLAR_EN.
- Defined: outData is the two's-complement bipolar value 2*ones - N, width DEP+1, range -N..+N saturated to the representable range.
  - +N saturates to N-1 (all-ones stream -> 2^DEP - 1).
  - The conversion is registered in the same cycle as the load; latency is unchanged.
- Undefined: outData is the unsigned ones count 0..N as described above.

Decomposition:
- Shared package gdiv_u_pkg holds:
  - typedef enum logic {IDLE, ACC} dec_state_t.
  - A function computing window length from DEP.
  - The bipolar conversion function, used under the macro.
- One sub-module: gdiv_u_decode_win. It contains winCnt and onesCnt plus the close detection, and emits a close pulse and the final count. The top level holds the FSM and the output register/handshake.

Test Plan (DEP=3, N=8 unless noted):
- All-ones, CONT=0, outReady=1:
  - start=1 for one cycle, bitIn=1 for 8 cycles -> outValid rises exactly 9 cycles after start, outData=8, busy low afterwards.
  - Bipolar build: outData=7 (saturated).
- Pattern 1,0 repeated, CONT=0:
  - -> outData=4 (bipolar build: 0).
  - start pulses during ACC -> no effect; a single result is produced.
- Backpressure, CONT=1, outReady=0:
  - bitIn all ones -> first result outData=8, overrun=0.
  - Second window all zeros -> outData=0, overrun=1 and stays 1 until reset.
- Simultaneous transfer and load, CONT=1:
  - outReady=1 only on the close cycle of window 2 -> window-1 value accepted, window-2 value loaded, outValid stays 1, overrun=0.
- Reset mid-window: assert rst_n=0 after 4 ACC cycles -> all outputs 0 immediately, state IDLE, no outValid after release.
- Random stream, DEP=5, bitIn=1 with probability 0.25 from an LFSR -> outData equals the scoreboard's ones count over exactly 32 samples, for 100 windows.
